seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL provide parameter STABLE_CYC, default 4: consecutive identical samples needed to accept a digit, range 2..15.
REQ-002 SHALL provide parameter TIMEOUT, default 200_000: cycles without a capture before the frame is declared stale (2 ms at 100 MHz).
REQ-003 SHALL have port sys_clk, input, 1 bit: single clock, 100 MHz; all logic on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port sel, input, 4 bits: scanned digit select, one-hot active-high; bit0 is the rightmost digit.
REQ-006 SHALL have port seg, input, 8 bits: bit7 is the decimal point, bits6..0 are segments g..a, all active-high.
REQ-007 SHALL have port data_out, output, 16 bits: decoded hex digits {d3,d2,d1,d0}.
REQ-008 SHALL have port point_out, output, 4 bits: decimal point per digit.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when data_out and point_out are updated.
REQ-010 SHALL have port frame_err, output, 1 bit: set when the last frame contained at least one undecodable pattern.
REQ-011 SHALL have port stale, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-012 SHALL register sel and seg once (sel_q, seg_q) before any use; no combinational path from input to output.
REQ-013 SHALL treat sel_q as valid only when it is exactly one-hot; 0000 and multi-hot values are invalid.
REQ-014 SHALL keep a stability counter that increments while {sel_q,seg_q} equals its previous value, clears on any change, and saturates at STABLE_CYC-1.
REQ-015 SHALL implement an FSM with these states and transitions:
- IDLE: go to SETTLE when sel_q is valid.
- SETTLE: go to CAPT when the counter reaches STABLE_CYC-1 with sel_q valid (capture this cycle); go to IDLE if sel_q becomes invalid.
- CAPT: go to SETTLE when sel_q changes to a different valid value; go to IDLE on invalid sel_q; stay while sel_q is unchanged, so there is at most one capture per select dwell.
REQ-016 SHALL decode seg_q[6:0] on capture using this table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
REQ-017 SHALL store an unlisted pattern as digit 0 and set the internal error flag for the current frame.
REQ-018 SHALL write each capture into the slot indexed by sel_q (digit nibble plus seg_q[7]) and set that slot's bit in a 4-bit capture mask.
REQ-019 SHALL, when a re-capture hits an already-set slot, overwrite the slot and leave the mask unchanged.
REQ-020 SHALL, on the capture that makes the mask 1111, do all of the following on the next edge:
- load data_out, point_out and frame_err from the slots (including this capture);
- pulse frame_valid high for 1 cycle;
- clear the mask and the error flag.
REQ-021 SHALL hold data_out, point_out and frame_err between frames.
REQ-022 SHALL give a frame latency of exactly STABLE_CYC+2 cycles, measured from the first cycle the final digit's sel/seg values appear at the ports to frame_valid high.
REQ-023 SHALL keep an 18-bit timeout counter that clears on every capture and otherwise increments.
REQ-024 SHALL, when the timeout counter reaches TIMEOUT-1, pulse stale for 1 cycle, clear the mask and the error flag, and restart the counter; FSM state is unaffected.
REQ-025 SHALL give capture priority if a capture and a timeout occur in the same cycle: no stale pulse, and the counter clears.
REQ-026 SHALL allow frame_valid and stale to never be high in the same cycle.

Reset
REQ-027 SHALL, with sys_rst high at a clock edge, set these values:
- FSM to IDLE;
- data_out 16'h0000, point_out 4'h0;
- frame_valid, frame_err and stale to 0;
- mask, slots, error flag and all counters to 0.
REQ-028 SHALL, on reset asserted mid-frame, discard partial captures; the first frame after reset needs all four digits again.

Verification
REQ-029 Basic frame: digits 1,2,3,4 (seg 06, 5B, 4F, 66; sel 0001, 0010, 0100, 1000), 1000 cycles each, point 0010 -> one frame_valid, data_out 16'h4321, point_out 4'b0010, frame_err 0, frame_valid 6 cycles after the sel=1000 dwell starts.
REQ-030 Glitch rejection: seg toggles every 2 cycles for 20 cycles within a dwell, then stable 0x7F -> exactly one capture, digit 8.
REQ-031 Bad pattern: digit slot 2 carries seg 0x00 -> data_out 16'hx0xx with that nibble 0, frame_err 1; the next clean frame returns frame_err 0.
REQ-032 Timeout: three digits, then sel held at 0000 for 200_000 cycles -> stale pulses once, no frame_valid; the following full frame reports only new digits.
REQ-033 Invalid select: sel 0011 held 100 cycles -> no capture, mask unchanged.
REQ-034 Reset mid-frame: reset asserted after two digits, then a full frame A,B,C,D -> data_out 16'hDCBA, exactly one frame_valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers the four hex digits shown on a scanned
// 7-segment display by watching the digit-select and segment lines.
// Each digit is accepted once its select/segment pattern has been steady
// for STABLE_CYC samples. A full set of four captures produces one frame.
// A frame that is not completed within TIMEOUT cycles of the last capture
// is discarded and reported with a stale pulse.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 200_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  sel,
    input  logic [7:0]  seg,
    output logic [15:0] data_out,
    output logic [3:0]  point_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale
);

    localparam logic [3:0]  CNT_MAX  = 4'(STABLE_CYC - 1);
    localparam logic [17:0] TMO_LAST = 18'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPT
    } state_t;

    // Registered copies of the inputs and of their previous values
    logic [3:0]  r_sel_q;
    logic [7:0]  r_seg_q;
    logic [3:0]  r_sel_prev;
    logic [7:0]  r_seg_prev;
    logic [3:0]  r_stab_cnt;

    // Scan state
    state_t      r_state;
    logic [3:0]  r_capt_sel;

    // Frame assembly
    logic [15:0] r_slot_dig;
    logic [3:0]  r_slot_dp;
    logic [3:0]  r_mask;
    logic        r_err;

    // Staleness watchdog
    logic [17:0] r_tmo_cnt;

    // Combinational helpers
    logic        w_sel_valid;
    logic        w_same;
    logic        w_capture;
    logic [3:0]  w_dec_nib;
    logic        w_dec_bad;
    logic [15:0] w_slot_dig_nxt;
    logic [3:0]  w_slot_dp_nxt;
    logic [3:0]  w_mask_nxt;
    logic        w_frame_done;
    logic        w_tmo_hit;

    assign w_sel_valid = $onehot(r_sel_q);
    assign w_same      = ({r_sel_q, r_seg_q} == {r_sel_prev, r_seg_prev});

    // The counter value lags the sample it describes by one cycle, so the
    // current sample must also match before it is taken; otherwise a pattern
    // that changes exactly on the qualifying cycle would be captured unsettled.
    assign w_capture   = (r_state == ST_SETTLE) && w_sel_valid && w_same &&
                         (r_stab_cnt == CNT_MAX);

    assign w_mask_nxt   = r_mask | r_sel_q;
    assign w_frame_done = w_capture && (w_mask_nxt == 4'hF);
    assign w_tmo_hit    = (r_tmo_cnt == TMO_LAST);

    // Input sampling and stability counting
    always_ff @(posedge sys_clk) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register sees the pre-edge value of every other register.
        if (sys_rst) begin
            r_sel_q    <= '0;
            r_seg_q    <= '0;
            r_sel_prev <= '0;
            r_seg_prev <= '0;
            r_stab_cnt <= '0;
        end else begin
            r_sel_q    <= sel;
            r_seg_q    <= seg;
            r_sel_prev <= r_sel_q;
            r_seg_prev <= r_seg_q;
            if (!w_same) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != CNT_MAX) begin
                r_stab_cnt <= r_stab_cnt + 4'd1;
            end
        end
    end

    // Segment pattern to hex digit; unknown patterns decode to 0 and flag
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        w_dec_nib = 4'h0;
        w_dec_bad = 1'b0;
        case (r_seg_q[6:0])
            7'h3F: w_dec_nib = 4'h0;
            7'h06: w_dec_nib = 4'h1;
            7'h5B: w_dec_nib = 4'h2;
            7'h4F: w_dec_nib = 4'h3;
            7'h66: w_dec_nib = 4'h4;
            7'h6D: w_dec_nib = 4'h5;
            7'h7D: w_dec_nib = 4'h6;
            7'h07: w_dec_nib = 4'h7;
            7'h7F: w_dec_nib = 4'h8;
            7'h6F: w_dec_nib = 4'h9;
            7'h77: w_dec_nib = 4'hA;
            7'h7C: w_dec_nib = 4'hB;
            7'h39: w_dec_nib = 4'hC;
            7'h5E: w_dec_nib = 4'hD;
            7'h79: w_dec_nib = 4'hE;
            7'h71: w_dec_nib = 4'hF;
            default: begin
                w_dec_nib = 4'h0;
                w_dec_bad = 1'b1;
            end
        endcase
    end

    // Slot contents as they would look with the current sample written in
    always_comb begin
        w_slot_dig_nxt = r_slot_dig;
        w_slot_dp_nxt  = r_slot_dp;
        for (int i = 0; i < 4; i++) begin
            if (r_sel_q[i]) begin
                w_slot_dig_nxt[i*4 +: 4] = w_dec_nib;
                w_slot_dp_nxt[i]         = r_seg_q[7];
            end
        end
    end

    // Scan FSM: at most one capture per select dwell
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_capt_sel <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!w_sel_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_capture) begin
                        r_state    <= ST_CAPT;
                        r_capt_sel <= r_sel_q;
                    end
                end
                ST_CAPT: begin
                    if (!w_sel_valid) begin
                        r_state <= ST_IDLE;
                    end else if (r_sel_q != r_capt_sel) begin
                        r_state <= ST_SETTLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Slot storage, capture mask, error flag and frame outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            // NOTE: the slot storage is cleared as well, so nothing captured
            // before reset can ever leak into a later frame.
            r_slot_dig  <= '0;
            r_slot_dp   <= '0;
            r_mask      <= '0;
            r_err       <= 1'b0;
            data_out    <= '0;
            point_out   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= w_frame_done;
            if (w_capture) begin
                r_slot_dig <= w_slot_dig_nxt;
                r_slot_dp  <= w_slot_dp_nxt;
                if (w_frame_done) begin
                    r_mask    <= '0;
                    r_err     <= 1'b0;
                    data_out  <= w_slot_dig_nxt;
                    point_out <= w_slot_dp_nxt;
                    frame_err <= r_err | w_dec_bad;
                end else begin
                    r_mask <= w_mask_nxt;
                    r_err  <= r_err | w_dec_bad;
                end
            end else if (w_tmo_hit) begin
                r_mask <= '0;
                r_err  <= 1'b0;
            end
        end
    end

    // Staleness watchdog; a capture in the same cycle wins over the timeout
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tmo_cnt <= '0;
            stale     <= 1'b0;
        end else if (w_capture) begin
            r_tmo_cnt <= '0;
            stale     <= 1'b0;
        end else if (w_tmo_hit) begin
            r_tmo_cnt <= '0;
            stale     <= 1'b1;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 18'd1;
            stale     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: directed scenarios plus random scanning,
// checked against an event-level model through a scoreboard queue.
module tb_seg_scan_decoder;

    localparam int STABLE_CYC = 4;
    localparam int TIMEOUT    = 3000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [15:0] data_out;
    logic [3:0]  point_out;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;

    seg_scan_decoder #(
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .sel         (sel),
        .seg         (seg),
        .data_out    (data_out),
        .point_out   (point_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle index: equals k after the k-th rising edge
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model (event level) ----------------
    typedef struct {
        bit          is_frame;
        int          at;
        logic [15:0] data;
        logic [3:0]  point;
        bit          err;
    } ev_t;

    ev_t exp_q[$];

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [3:0]  m_dig [4];
    bit          m_dp  [4];
    bit          m_mask[4];
    bit          m_err;
    int          m_last_ref;
    logic [11:0] m_run_val;
    int          m_run_start;
    int          m_run_len;
    logic [3:0]  m_dwell_sel;
    bit          m_dwell_capt;

    // Emit every stale event due at or before edge 'limit'
    function automatic void model_flush(input int limit);
        while (m_last_ref + TIMEOUT <= limit) begin
            ev_t ev;
            m_last_ref += TIMEOUT;
            ev.is_frame = 0; ev.at = m_last_ref; ev.data = '0; ev.point = '0; ev.err = 0;
            exp_q.push_back(ev);
            for (int i = 0; i < 4; i++) m_mask[i] = 0;
            m_err = 0;
        end
    endfunction

    function automatic void model_capture(input int c, input logic [3:0] s, input logic [7:0] g);
        int         idx = 0;
        logic [3:0] nib = 4'h0;
        bit         bad = 1;
        bit         full = 1;
        model_flush(c - 1);
        for (int i = 0; i < 4; i++) if (s[i]) idx = i;
        for (int v = 0; v < 16; v++) if (seg_tab[v] == g[6:0]) begin nib = 4'(v); bad = 0; end
        m_dig[idx]  = nib;
        m_dp[idx]   = g[7];
        m_mask[idx] = 1;
        m_err       = m_err | bad;
        for (int i = 0; i < 4; i++) full = full & m_mask[i];
        if (full) begin
            ev_t ev;
            ev.is_frame = 1; ev.at = c; ev.err = m_err;
            for (int i = 0; i < 4; i++) begin
                ev.data[i*4 +: 4] = m_dig[i];
                ev.point[i]       = m_dp[i];
            end
            exp_q.push_back(ev);
            for (int i = 0; i < 4; i++) m_mask[i] = 0;
            m_err = 0;
        end
        m_last_ref = c;
    endfunction

    // A run of identical port values lasting STABLE_CYC+1 cycles inside a
    // select dwell that has not captured yet yields a capture STABLE_CYC+2
    // edges after the run starts.
    function automatic void model_run(input logic [3:0] s, input logic [7:0] g, input int n, input int t0);
        if ({s, g} != m_run_val) begin
            m_run_val   = {s, g};
            m_run_start = t0;
            m_run_len   = 0;
            if (s != m_dwell_sel) begin
                m_dwell_sel  = s;
                m_dwell_capt = 0;
            end
        end
        m_run_len += n;
        if (!m_dwell_capt && $countones(s) == 1 && m_run_len >= STABLE_CYC + 1) begin
            m_dwell_capt = 1;
            model_capture(m_run_start + STABLE_CYC + 2, s, g);
        end
        model_flush(t0 + n);
    endfunction

    function automatic void model_reset(input int r);
        for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_dp[i] = 0; m_mask[i] = 0; end
        m_err        = 0;
        m_last_ref   = r;
        m_run_val    = '0;
        m_run_start  = r;
        m_run_len    = 0;
        m_dwell_sel  = '0;
        m_dwell_capt = 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] s, input logic [7:0] g, input int n);
        model_run(s, g, n, cyc);
        sel = s;
        seg = g;
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic digit(input int slot, input int nib, input bit dp, input int len);
        logic [7:0] g;
        g = {dp, seg_tab[nib]};
        drive(4'(1 << slot), g, len);
    endtask

    task automatic apply_reset(input int m);
        int k;
        drive(4'h0, 8'h00, 8);
        k = cyc;
        model_flush(k);
        sys_rst = 1'b1;
        repeat (m) begin @(posedge sys_clk); #1; end
        sys_rst = 1'b0;
        model_reset(k + m);
    endtask

    // ---------------- monitor ----------------
    int n_frames    = 0;
    int n_stale     = 0;
    int last_fv_cyc = 0;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (frame_valid || stale) begin
                check("pulse_overlap", {31'd0, frame_valid & stale}, 32'd0);
                if (frame_valid) begin n_frames++; last_fv_cyc = cyc; end
                if (stale) n_stale++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, frame_valid, stale}, 32'd0);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("event_kind_is_frame", {31'd0, frame_valid}, {31'd0, ev.is_frame});
                    check("event_cycle", cyc, ev.at);
                    if (ev.is_frame && frame_valid) begin
                        check("frame_data", {16'd0, data_out}, {16'd0, ev.data});
                        check("frame_point", {28'd0, point_out}, {28'd0, ev.point});
                        check("frame_err", {31'd0, frame_err}, {31'd0, ev.err});
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                ev_t ev;
                ev = exp_q.pop_front();
                check("missed_event_cycle", cyc, ev.at);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t_start;
        int f0;
        int s0;

        sys_rst = 1'b1;
        sel     = '0;
        seg     = '0;
        repeat (3) begin @(posedge sys_clk); #1; end
        sys_rst = 1'b0;
        model_reset(cyc);

        check("reset_data_out",    {16'd0, data_out}, 32'd0);
        check("reset_point_out",   {28'd0, point_out}, 32'd0);
        check("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("reset_frame_err",   {31'd0, frame_err}, 32'd0);
        check("reset_stale",       {31'd0, stale}, 32'd0);

        // Basic frame 1,2,3,4 with the point on digit 1
        f0 = n_frames;
        digit(0, 1, 1'b0, 1000);
        digit(1, 2, 1'b1, 1000);
        digit(2, 3, 1'b0, 1000);
        t_start = cyc;
        digit(3, 4, 1'b0, 1000);
        check("basic_data",    {16'd0, data_out}, 32'h4321);
        check("basic_point",   {28'd0, point_out}, 32'b0010);
        check("basic_err",     {31'd0, frame_err}, 32'd0);
        check("basic_frames",  n_frames - f0, 32'd1);
        check("basic_latency", last_fv_cyc - t_start, STABLE_CYC + 2);

        // Glitch rejection on the last digit
        f0 = n_frames;
        digit(0, 5, 1'b0, 20);
        digit(1, 6, 1'b0, 20);
        digit(2, 7, 1'b0, 20);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1000, 8'h06, 2);
            drive(4'b1000, 8'h5B, 2);
        end
        drive(4'b1000, 8'h7F, 20);
        check("glitch_data",   {16'd0, data_out}, 32'h8765);
        check("glitch_frames", n_frames - f0, 32'd1);

        // Undecodable pattern in slot 2, then a clean frame
        digit(0, 1, 1'b0, 20);
        digit(1, 2, 1'b0, 20);
        drive(4'b0100, 8'h00, 20);
        digit(3, 3, 1'b0, 20);
        check("bad_data", {16'd0, data_out}, 32'h3021);
        check("bad_err",  {31'd0, frame_err}, 32'd1);
        digit(0, 9, 1'b0, 20);
        digit(1, 10, 1'b0, 20);
        digit(2, 11, 1'b0, 20);
        digit(3, 12, 1'b0, 20);
        check("clean_data", {16'd0, data_out}, 32'hCBA9);
        check("clean_err",  {31'd0, frame_err}, 32'd0);

        // Timeout after three digits discards them
        f0 = n_frames;
        s0 = n_stale;
        digit(0, 14, 1'b0, 20);
        digit(1, 14, 1'b0, 20);
        digit(2, 14, 1'b0, 20);
        drive(4'b0000, 8'h00, TIMEOUT + 50);
        check("timeout_stale_count", n_stale - s0, 32'd1);
        digit(3, 5, 1'b0, 20);
        check("timeout_no_frame", n_frames - f0, 32'd0);
        digit(0, 7, 1'b0, 20);
        digit(1, 8, 1'b0, 20);
        digit(2, 9, 1'b0, 20);
        check("timeout_new_data", {16'd0, data_out}, 32'h5987);

        // Invalid multi-hot select is ignored
        f0 = n_frames;
        digit(0, 6, 1'b0, 20);
        digit(1, 7, 1'b0, 20);
        drive(4'b0011, 8'h06, 100);
        digit(2, 8, 1'b0, 20);
        check("invalid_no_frame", n_frames - f0, 32'd0);
        digit(3, 9, 1'b0, 20);
        check("invalid_data", {16'd0, data_out}, 32'h9876);

        // Reset in the middle of a frame
        digit(0, 1, 1'b0, 20);
        digit(1, 2, 1'b0, 20);
        apply_reset(4);
        check("midreset_data_out", {16'd0, data_out}, 32'd0);
        f0 = n_frames;
        digit(0, 10, 1'b0, 20);
        digit(1, 11, 1'b0, 20);
        digit(2, 12, 1'b0, 20);
        digit(3, 13, 1'b0, 20);
        check("midreset_data",   {16'd0, data_out}, 32'hDCBA);
        check("midreset_frames", n_frames - f0, 32'd1);

        // Random scanning, including invalid selects and bad patterns
        for (int i = 0; i < 400; i++) begin
            logic [3:0] s;
            logic [7:0] g;
            int r;
            r = $urandom_range(0, 9);
            if (r < 8)       s = 4'(1 << (r % 4));
            else if (r == 8) s = 4'h0;
            else             s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) g = 8'($urandom_range(0, 255));
            else                           g = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
            drive(s, g, $urandom_range(1, 12));
        end

        drive(4'h0, 8'h00, 20);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
